// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA stream scheduler.
package vga_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    WAIT_SOP = 2'd0,
    ARMED    = 2'd1,
    RUN      = 2'd2
  } sched_state_t;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int CLK_DIV_DEF  = 2;

  // Colour-bar palette, left to right across the active line.
  function automatic rgb_t bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_colour = rgb_t'(24'hFFFFFF);
      3'd1:    bar_colour = rgb_t'(24'hFFFF00);
      3'd2:    bar_colour = rgb_t'(24'h00FFFF);
      3'd3:    bar_colour = rgb_t'(24'h00FF00);
      3'd4:    bar_colour = rgb_t'(24'hFF00FF);
      3'd5:    bar_colour = rgb_t'(24'hFF0000);
      3'd6:    bar_colour = rgb_t'(24'h0000FF);
      default: bar_colour = rgb_t'(24'h000000);
    endcase
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-clock divider plus horizontal/vertical raster counters and sync decode.
// With TEST_PATTERN_EN defined it also exports the colour-bar index of the current pixel.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int DW      = $clog2(CLK_DIV),
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic       clk,
  input  logic       reset_n,
`ifdef TEST_PATTERN_EN
  output logic [2:0] bar_o,
`endif
  output logic       tick_o,
  output logic       active_o,
  output logic       first_px_o,
  output logic       hs_o,
  output logic       vs_o,
  output logic       vga_clk_o
);

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  always_comb begin
    tick_o = (div_q == DW'(CLK_DIV - 1));
    div_d  = tick_o ? '0 : div_q + DW'(1);
    h_d    = h_q;
    v_d    = v_q;
    if (tick_o) begin
      if (h_q == HW'(H_TOTAL - 1)) begin
        h_d = '0;
        v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + VW'(1);
      end else begin
        h_d = h_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  // Sync windows compared in int to stay safe when a porch is zero.
  assign active_o   = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
  assign first_px_o = (h_q == '0) && (v_q == '0);
  assign hs_o       = !((int'(h_q) >= H_ACTIVE + H_FP) && (int'(h_q) < H_ACTIVE + H_FP + H_SYNC));
  assign vs_o       = !((int'(v_q) >= V_ACTIVE + V_FP) && (int'(v_q) < V_ACTIVE + V_FP + V_SYNC));
  assign vga_clk_o  = int'(div_q) >= CLK_DIV / 2;
`ifdef TEST_PATTERN_EN
  assign bar_o      = 3'(int'(h_q) / (H_ACTIVE / 8));
`endif

endmodule

// File: rtl/vga_stream_scheduler.sv
// Paces an RGB888 ready/valid stream onto VGA pins, keeping it frame-aligned via SOP.
// Optional colour-bar generator enabled by defining TEST_PATTERN_EN (adds pattern_sel).
module vga_stream_scheduler
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int CLK_DIV  = CLK_DIV_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] in_data,
  input  logic        in_valid,
  input  logic        in_sop,
`ifdef TEST_PATTERN_EN
  input  logic        pattern_sel,
`endif
  output logic        in_ready,
  output logic        frame_start,
  output logic        locked,
  output logic [15:0] underflow_cnt,
  output logic        vga_clk,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank,
  output logic        vga_sync,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b
);

  logic tick, active, first_px, hs_c, vs_c;
`ifdef TEST_PATTERN_EN
  logic [2:0] bar;
`endif

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CLK_DIV(CLK_DIV)
  ) u_timing (
    .clk       (clk),
    .reset_n   (reset_n),
`ifdef TEST_PATTERN_EN
    .bar_o     (bar),
`endif
    .tick_o    (tick),
    .active_o  (active),
    .first_px_o(first_px),
    .hs_o      (hs_c),
    .vs_o      (vs_c),
    .vga_clk_o (vga_clk)
  );

  sched_state_t state_q, state_d;
  logic [15:0]  uf_q, uf_d;
  rgb_t         rgb_q, pix_d;
  logic         hs_q, vs_q, blank_q;
  logic         ready_c, run_now, pix_slot;

  assign frame_start = tick & first_px;
  assign pix_slot    = tick & active;
  // An ARMED scheduler owns the (0,0) slot itself, so the held SOP beat is taken at frame_start.
  assign run_now     = (state_q == RUN) || ((state_q == ARMED) && frame_start);

  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    pix_d   = '0;
    uf_d    = uf_q;
    case (state_q)
      WAIT_SOP: begin
        ready_c = !(in_valid && in_sop);
        if (in_valid && in_sop) state_d = ARMED;
      end
      default: begin
        if (run_now) begin
          ready_c = pix_slot && !(in_sop && !first_px);
          if (pix_slot) begin
            state_d = RUN;
            if (!in_valid) begin
              if (uf_q != 16'hFFFF) uf_d = uf_q + 16'd1;
            end else if (in_sop && !first_px) begin
              state_d = ARMED;
            end else begin
              pix_d = rgb_t'(in_data);
              if (first_px && !in_sop) state_d = WAIT_SOP;
            end
          end
        end
      end
    endcase
`ifdef TEST_PATTERN_EN
    if (pattern_sel) begin
      state_d = WAIT_SOP;
      ready_c = 1'b0;
      uf_d    = uf_q;
      pix_d   = active ? bar_colour(bar) : '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_SOP;
      uf_q    <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      rgb_q   <= '0;
    end else begin
      state_q <= state_d;
      uf_q    <= uf_d;
      if (tick) begin
        hs_q    <= hs_c;
        vs_q    <= vs_c;
        blank_q <= active;
        rgb_q   <= pix_d;
      end
    end
  end

  // Gated by reset_n so the handshake is closed while reset is held.
  assign in_ready      = reset_n & ready_c;
  assign locked        = (state_q == RUN);
  assign underflow_cnt = uf_q;
  assign vga_hs        = hs_q;
  assign vga_vs        = vs_q;
  assign vga_blank     = blank_q;
  assign vga_sync      = 1'b0;
  assign vga_r         = rgb_q.r;
  assign vga_g         = rgb_q.g;
  assign vga_b         = rgb_q.b;

endmodule

// File: tb/tb_vga_stream_scheduler.sv
// Randomized bench for vga_stream_scheduler on a shrunken raster, checked against a queue-based model.
module tb_vga_stream_scheduler;

  localparam int HA = 16, HF = 2, HS = 4, HB = 2;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
  localparam int CD = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME_CLKS = HT * VT * CD;
  localparam int M_HUNT = 0, M_ARM = 1, M_RUN = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [23:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_sop = 1'b0;
  logic        in_ready, frame_start, locked;
  logic [15:0] underflow_cnt;
  logic        vga_clk, vga_hs, vga_vs, vga_blank, vga_sync;
  logic [7:0]  vga_r, vga_g, vga_b;
`ifdef TEST_PATTERN_EN
  logic        pattern_sel = 1'b0;
`endif

  vga_stream_scheduler #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(CD)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_sop       (in_sop),
`ifdef TEST_PATTERN_EN
    .pattern_sel  (pattern_sel),
`endif
    .in_ready     (in_ready),
    .frame_start  (frame_start),
    .locked       (locked),
    .underflow_cnt(underflow_cnt),
    .vga_clk      (vga_clk),
    .vga_hs       (vga_hs),
    .vga_vs       (vga_vs),
    .vga_blank    (vga_blank),
    .vga_sync     (vga_sync),
    .vga_r        (vga_r),
    .vga_g        (vga_g),
    .vga_b        (vga_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sop;
    logic [23:0] data;
  } beat_t;

  beat_t       src_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          k;
  int          mode;
  int          e_uf;
  logic        e_hs, e_vs, e_blank;
  logic [23:0] e_rgb;
  bit          gap_mode = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    k = 0; mode = M_HUNT; e_uf = 0;
    e_hs = 1'b1; e_vs = 1'b1; e_blank = 1'b0; e_rgb = '0;
    src_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, in_ready, 0);
    check({tag, "_fs"}, frame_start, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_uf"}, underflow_cnt, 0);
    check({tag, "_hs"}, vga_hs, 1);
    check({tag, "_vs"}, vga_vs, 1);
    check({tag, "_blank"}, vga_blank, 0);
    check({tag, "_sync"}, vga_sync, 0);
    check({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
    check({tag, "_vgaclk"}, vga_clk, 0);
  endtask

  task automatic push_frame(input int n, input bit with_sop, input bit ramp);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.sop  = with_sop && (i == 0);
      b.data = ramp ? 24'(i % HA) : 24'($urandom);
      src_q.push_back(b);
    end
  endtask

  // One clock: drive at the falling edge, check 1 ns later, then advance the model over the rising edge.
  task automatic step();
    int p, h, v;
    bit tick, act, first, fs, run_now, exp_rdy, valid, sop;
    logic [23:0] d;
    if (src_q.size() > 0 && (!gap_mode || $urandom_range(3) != 0)) begin
      valid = 1'b1; sop = src_q[0].sop; d = src_q[0].data;
    end else begin
      valid = 1'b0; sop = 1'($urandom_range(1)); d = 24'($urandom);
    end
    in_valid = valid; in_sop = sop; in_data = d;
    #1;
    p = k / CD;
    h = p % HT;
    v = (p / HT) % VT;
    tick    = (k % CD) == CD - 1;
    act     = (h < HA) && (v < VA);
    first   = (h == 0) && (v == 0);
    fs      = tick && first;
    run_now = (mode == M_RUN) || (mode == M_ARM && fs);
    if (mode == M_HUNT)  exp_rdy = !(valid && sop);
    else if (run_now)    exp_rdy = tick && act && !(sop && !first);
    else                 exp_rdy = 1'b0;

    check("in_ready", in_ready, exp_rdy);
    check("frame_start", frame_start, fs);
    check("vga_clk", vga_clk, (k % CD) >= CD / 2);
    check("vga_hs", vga_hs, e_hs);
    check("vga_vs", vga_vs, e_vs);
    check("vga_blank", vga_blank, e_blank);
    check("vga_sync", vga_sync, 0);
    check("rgb", {vga_r, vga_g, vga_b}, e_rgb);
    check("locked", locked, mode == M_RUN);
    check("underflow", underflow_cnt, e_uf);

    if (tick) begin
      e_hs    = !(h >= HA + HF && h < HA + HF + HS);
      e_vs    = !(v >= VA + VF && v < VA + VF + VS);
      e_blank = act;
      e_rgb   = '0;
    end
    if (mode == M_HUNT) begin
      if (valid && sop) mode = M_ARM;
    end else if (run_now && tick && act) begin
      mode = M_RUN;
      if (!valid) begin
        if (e_uf < 65535) e_uf++;
      end else if (sop && !first) begin
        mode = M_ARM;
      end else begin
        e_rgb = d;
        if (first && !sop) mode = M_HUNT;
      end
    end
    if (valid && exp_rdy) void'(src_q.pop_front());
    @(negedge clk);
    k++;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain(input string tag, input int bound);
    int n = 0;
    while (src_q.size() > 0 && n < bound) begin
      step();
      n++;
    end
    check({tag, "_drain_timeout"}, src_q.size(), 0);
  endtask

  initial begin
    // Power-on reset, asynchronously applied between clock edges.
    #1 reset_n = 1'b0;
    #1 check_reset_vals("por");
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("por_held");
    reset_n = 1'b1;
    model_reset();

    // Idle stream: raster runs, nothing locks, no underflow.
    run_cycles(FRAME_CLKS + 120);
    check("idle_uf", underflow_cnt, 0);
    check("idle_locked", locked, 0);

    // Aligned stream: ramp frame then random frames, always valid.
    push_frame(HA * VA, 1'b1, 1'b1);
    push_frame(HA * VA, 1'b1, 1'b0);
    push_frame(HA * VA, 1'b1, 1'b0);
    drain("stream", 6 * FRAME_CLKS);
    check("stream_locked", locked, 1);
    check("stream_uf", underflow_cnt, 0);

    // Early SOP: a short frame forces a realign on the following frame.
    push_frame(40, 1'b1, 1'b0);
    push_frame(HA * VA, 1'b1, 1'b0);
    drain("early_sop", 6 * FRAME_CLKS);
    check("early_sop_locked", locked, 1);
    check("early_sop_uf", underflow_cnt, 0);

    // Missing SOP: first beat consumed, rest flushed, next SOP relocks.
    push_frame(HA * VA, 1'b0, 1'b0);
    push_frame(HA * VA, 1'b1, 1'b0);
    drain("no_sop", 6 * FRAME_CLKS);
    check("no_sop_locked", locked, 1);

    // Random valid gaps with frames of random length.
    gap_mode = 1'b1;
    for (int f = 0; f < 6; f++) push_frame($urandom_range(HA * VA + 20, 60), 1'b1, 1'b0);
    drain("gaps", 30 * FRAME_CLKS);
    run_cycles(FRAME_CLKS / 2);
    gap_mode = 1'b0;

    // Mid-frame asynchronous reset on line 3.
    push_frame(HA * VA, 1'b1, 1'b0);
    push_frame(HA * VA, 1'b1, 1'b0);
    begin
      int n = 0;
      while ((((k / CD) / HT) % VT) != 3 && n < 3 * FRAME_CLKS) begin
        step();
        n++;
      end
      check("reach_line3_timeout", (((k / CD) / HT) % VT), 3);
    end
    #2 reset_n = 1'b0;
    #1 check_reset_vals("mid_rst");
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("mid_rst_held");
    reset_n = 1'b1;
    model_reset();
    push_frame(HA * VA, 1'b1, 1'b1);
    push_frame(HA * VA, 1'b1, 1'b0);
    drain("post_rst", 6 * FRAME_CLKS);
    check("post_rst_locked", locked, 1);
    run_cycles(40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
